// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one multicycle ALU between two requesters
module alu_arbiter #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_sel,
  input  logic        req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_sel,
  input  logic        req1_ctrl,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_res,
  output logic        resp_zf,
  output logic        resp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_ctrl,
  input  logic [31:0] alu_res,
  output logic        busy
);

  // Cycle budgets are clamped to at least one EXEC cycle.
  localparam int MUL_C = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int DIV_C = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;
  localparam logic [7:0] MUL_LD = 8'(MUL_C - 1);
  localparam logic [7:0] DIV_LD = 8'(DIV_C - 1);

  localparam logic [2:0] SEL_MUL = 3'b010;
  localparam logic [2:0] SEL_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        owner;      // requester whose op is in flight
  logic        prio;       // 0: req0 wins a tie, 1: req1 wins a tie
  logic        gnt1;       // arbitration result: 1 selects req1
  logic        accept;
  logic        owner_take;
  logic [31:0] pick_a;
  logic [31:0] pick_b;
  logic [2:0]  pick_sel;
  logic        pick_ctrl;
  logic [7:0]  pick_ld;
  logic        div_zero;

  // Grant: a lone valid wins outright, a tie goes to the requester not served last.
  always_comb begin
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt1 = prio;
    end else begin
      gnt1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !gnt1;
  assign req1_ready = (state == IDLE) && req1_valid && gnt1;
  assign accept     = req0_ready || req1_ready;

  assign resp0_valid = (state == RESP) && !owner;
  assign resp1_valid = (state == RESP) && owner;
  assign busy        = (state != IDLE);
  assign owner_take  = owner ? resp1_ready : resp0_ready;

  // Payload of the granted requester and its EXEC cycle budget.
  always_comb begin
    pick_a    = gnt1 ? req1_a    : req0_a;
    pick_b    = gnt1 ? req1_b    : req0_b;
    pick_sel  = gnt1 ? req1_sel  : req0_sel;
    pick_ctrl = gnt1 ? req1_ctrl : req0_ctrl;
    case (pick_sel)
      SEL_MUL: pick_ld = MUL_LD;
      SEL_DIV: pick_ld = DIV_LD;
      default: pick_ld = 8'd0;
    endcase
  end

  // Divide-by-zero is judged on the latched operands the ALU is actually seeing.
  assign div_zero = (alu_sel == SEL_DIV) && (alu_b == 32'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: accept -> run the budget out -> hold until the owner takes the result.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: if (cnt == 8'd0) state_nx = RESP;
      RESP: if (owner_take) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, cycle counter, priority pointer and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
      alu_sel  <= 3'd0;
      alu_ctrl <= 1'b0;
      owner    <= 1'b0;
      prio     <= 1'b0;
      cnt      <= 8'd0;
      resp_res <= 32'd0;
      resp_zf  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= pick_a;
            alu_b    <= pick_b;
            alu_sel  <= pick_sel;
            alu_ctrl <= pick_ctrl;
            owner    <= gnt1;
            prio     <= !gnt1;
            cnt      <= pick_ld;
          end
        end
        EXEC: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (div_zero) begin
            resp_res <= 32'd0;
            resp_zf  <= 1'b1;
            resp_err <= 1'b1;
          end else begin
            resp_res <= alu_res;
            resp_zf  <= (alu_res == 32'd0);
            resp_err <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_ctrl;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_sel;
  logic        req1_valid, req1_ready, req1_ctrl;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_sel;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_res;
  logic        resp_zf, resp_err;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_sel;
  logic        alu_ctrl;
  logic        busy;

  typedef struct packed {
    logic        owner;
    logic [31:0] res;
    logic        zf;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  alu_arbiter #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_ctrl(req1_ctrl),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_res(resp_res), .resp_zf(resp_zf), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; divide-by-zero returns junk so the arbiter's override is visible.
  always_comb begin
    alu_res = 32'd0;
    case (alu_sel)
      3'b000: alu_res = alu_a + alu_b;
      3'b001: alu_res = alu_ctrl ? {31'd0, ($signed(alu_a) < $signed(alu_b))} : alu_a - alu_b;
      3'b010: alu_res = alu_a * alu_b;
      3'b011: alu_res = (alu_b == 32'd0) ? 32'hdeadbeef : 32'($signed(alu_a) / $signed(alu_b));
      3'b100: alu_res = alu_a & alu_b;
      3'b101: alu_res = alu_a | alu_b;
      3'b110: alu_res = alu_a ^ alu_b;
      default: alu_res = ~(alu_a | alu_b);
    endcase
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input bit owner, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sel, input logic ctrl);
    if (owner) begin
      req1_a = a; req1_b = b; req1_sel = sel; req1_ctrl = ctrl; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_sel = sel; req0_ctrl = ctrl; req0_valid = 1'b1;
    end
  endtask

  task automatic push(input bit owner, input logic [31:0] res, input logic zf, input logic err);
    exp_t e;
    e.owner = owner; e.res = res; e.zf = zf; e.err = err;
    sbq.push_back(e);
  endtask

  task automatic pop(output exp_t e, output bit ok);
    ok = (sbq.size() != 0);
    e  = '0;
    if (ok) e = sbq.pop_front();
  endtask

  // Drives one request, waits for its accept and its response; returns observations only.
  task automatic exec_op(input bit owner, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sel, input logic ctrl,
                         output bit rdy_first, output int lat, output bit ok);
    int n;
    step();
    set_req(owner, a, b, sel, ctrl);
    #1;
    rdy_first = owner ? req1_ready : req0_ready;
    n = 0;
    while (!(owner ? req1_ready : req0_ready) && n < 20) begin step(); n++; end
    ok = (n < 20);
    step();
    if (owner) req1_valid = 1'b0; else req0_valid = 1'b0;
    lat = 0;
    while (!(owner ? resp1_valid : resp0_valid) && lat < 50) begin step(); lat++; end
    if (lat >= 50) ok = 1'b0;
  endtask

  task automatic test_reset();
    bit stale;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, req0_ready, req1_ready, resp0_valid, resp1_valid, resp_res, resp_zf, resp_err,
         alu_a, alu_b, alu_sel, alu_ctrl} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b rv=%b%b res=%h alu_a=%h alu_b=%h sel=%b want all 0",
               busy, resp0_valid, resp1_valid, resp_res, alu_a, alu_b, alu_sel);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    set_req(1'b0, 32'd100, 32'd5, 3'b011, 1'b0);
    #1;
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL reset_pre_accept: ready=%b want 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    step();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL reset_mid_exec_busy: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, resp0_valid, resp1_valid, alu_a, alu_b, alu_sel, alu_ctrl} !== '0) begin
      fails++;
      $display("FAIL reset_async: busy=%b rv=%b%b alu_a=%h alu_b=%h sel=%b ctrl=%b want 0",
               busy, resp0_valid, resp1_valid, alu_a, alu_b, alu_sel, alu_ctrl);
    end
    step(); step();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp0_valid || resp1_valid || busy) stale = 1'b1;
    end
    tests++;
    if (stale !== 1'b0) begin
      fails++; $display("FAIL reset_no_stale: stale=%b want 0", stale);
    end
  endtask

  task automatic test_contention();
    int   n;
    int   lat;
    bit   g;
    bit   ok;
    exp_t e;
    set_req(1'b0, 32'd9, 32'd9, 3'b001, 1'b0);
    set_req(1'b1, 32'd3, 32'd3, 3'b110, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin step(); n++; end
      tests++;
      if (n >= 20 || (req0_ready && req1_ready)) begin
        fails++;
        $display("FAIL cont_ready_%0d: ready0=%b ready1=%b want exactly one", i, req0_ready, req1_ready);
      end
      g = req1_ready;
      tests++;
      if (g !== 1'(i % 2)) begin
        fails++; $display("FAIL cont_grant_%0d: granted=%0d want %0d", i, g, i % 2);
      end
      push(g, 32'd0, 1'b1, 1'b0);
      step();
      lat = 0;
      while (!(resp0_valid || resp1_valid) && lat < 20) begin step(); lat++; end
      tests++;
      if (req0_ready || req1_ready) begin
        fails++; $display("FAIL cont_wait_%0d: ready0=%b ready1=%b want 0 0", i, req0_ready, req1_ready);
      end
      pop(e, ok);
      tests++;
      if (!ok || lat >= 20 || resp1_valid !== e.owner || resp0_valid !== !e.owner ||
          resp_res !== e.res || resp_zf !== e.zf || resp_err !== e.err) begin
        fails++;
        $display("FAIL cont_resp_%0d: rv=%b%b res=%h zf=%b err=%b want owner=%0d res=%h zf=%b err=%b",
                 i, resp1_valid, resp0_valid, resp_res, resp_zf, resp_err, e.owner, e.res, e.zf, e.err);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single_add();
    bit   rdy, ok, pok;
    int   lat;
    exp_t e;
    push(1'b0, 32'd12, 1'b0, 1'b0);
    exec_op(1'b0, 32'd5, 32'd7, 3'b000, 1'b0, rdy, lat, ok);
    tests++;
    if (rdy !== 1'b1 || lat != 1 || !ok) begin
      fails++; $display("FAIL add_timing: ready_first=%b latency=%0d want ready 1 latency 1", rdy, lat);
    end
    pop(e, pok);
    tests++;
    if (!pok || resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_res !== e.res ||
        resp_zf !== e.zf || resp_err !== e.err) begin
      fails++;
      $display("FAIL add_resp: rv=%b%b res=%0d zf=%b err=%b want res=%0d zf=%b err=%b",
               resp1_valid, resp0_valid, resp_res, resp_zf, resp_err, e.res, e.zf, e.err);
    end
  endtask

  task automatic test_mul_div();
    bit   rdy, ok, pok;
    int   lat;
    exp_t e;
    push(1'b1, -32'sd6, 1'b0, 1'b0);
    exec_op(1'b1, -32'sd20, 32'd3, 3'b011, 1'b0, rdy, lat, ok);
    pop(e, pok);
    tests++;
    if (!ok || !pok || lat != DIV_CYCLES || resp_res !== e.res || resp_zf !== e.zf || resp_err !== e.err) begin
      fails++;
      $display("FAIL div_resp: latency=%0d res=%0d zf=%b err=%b want latency=%0d res=%0d zf=%b err=%b",
               lat, $signed(resp_res), resp_zf, resp_err, DIV_CYCLES, $signed(e.res), e.zf, e.err);
    end
    push(1'b1, 32'd0, 1'b1, 1'b1);
    exec_op(1'b1, 32'd77, 32'd0, 3'b011, 1'b0, rdy, lat, ok);
    pop(e, pok);
    tests++;
    if (!ok || !pok || lat != DIV_CYCLES || resp_res !== e.res || resp_zf !== e.zf || resp_err !== e.err) begin
      fails++;
      $display("FAIL div_zero: latency=%0d res=%h zf=%b err=%b want latency=%0d res=%h zf=%b err=%b",
               lat, resp_res, resp_zf, resp_err, DIV_CYCLES, e.res, e.zf, e.err);
    end
    push(1'b0, -32'sd42, 1'b0, 1'b0);
    exec_op(1'b0, 32'd6, -32'sd7, 3'b010, 1'b0, rdy, lat, ok);
    pop(e, pok);
    tests++;
    if (!ok || !pok || lat != MUL_CYCLES || resp_res !== e.res || resp_zf !== e.zf || resp_err !== e.err) begin
      fails++;
      $display("FAIL mul_resp: latency=%0d res=%0d zf=%b err=%b want latency=%0d res=%0d zf=%b err=%b",
               lat, $signed(resp_res), resp_zf, resp_err, MUL_CYCLES, $signed(e.res), e.zf, e.err);
    end
  endtask

  task automatic test_slt();
    bit   rdy, ok, pok;
    int   lat;
    exp_t e;
    push(1'b0, 32'd1, 1'b0, 1'b0);
    exec_op(1'b0, -32'sd1, 32'd2, 3'b001, 1'b1, rdy, lat, ok);
    pop(e, pok);
    tests++;
    if (!ok || !pok || resp_res !== e.res || resp_zf !== e.zf || resp_err !== e.err) begin
      fails++; $display("FAIL slt_true: res=%0d zf=%b want res=%0d zf=%b", resp_res, resp_zf, e.res, e.zf);
    end
    push(1'b1, 32'd0, 1'b1, 1'b0);
    exec_op(1'b1, 32'd4, 32'd2, 3'b001, 1'b1, rdy, lat, ok);
    pop(e, pok);
    tests++;
    if (!ok || !pok || resp_res !== e.res || resp_zf !== e.zf || resp_err !== e.err) begin
      fails++; $display("FAIL slt_false: res=%0d zf=%b want res=%0d zf=%b", resp_res, resp_zf, e.res, e.zf);
    end
  endtask

  task automatic test_backpressure();
    bit   rdy, ok, pok;
    int   lat;
    exp_t e;
    resp0_ready = 1'b0;
    push(1'b0, 32'd123, 1'b0, 1'b0);
    exec_op(1'b0, 32'd100, 32'd23, 3'b000, 1'b0, rdy, lat, ok);
    pop(e, pok);
    tests++;
    if (!ok || !pok || resp_res !== e.res) begin
      fails++; $display("FAIL bp_first: res=%0d want %0d", resp_res, e.res);
    end
    set_req(1'b1, 32'h0000_00f0, 32'h0000_003c, 3'b100, 1'b0);
    push(1'b1, 32'h0000_0030, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_res !== e.res || req1_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d: rv0=%b rv1=%b res=%0d ready1=%b want 1 0 %0d 0",
                 i, resp0_valid, resp1_valid, resp_res, req1_ready, e.res);
      end
      step();
    end
    resp0_ready = 1'b1;
    #1;
    tests++;
    if (req1_ready !== 1'b0) begin
      fails++; $display("FAIL bp_no_bypass: ready1=%b want 0", req1_ready);
    end
    step();
    tests++;
    if (req1_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL bp_next_grant: ready1=%b busy=%b want 1 0", req1_ready, busy);
    end
    step();
    req1_valid = 1'b0;
    lat = 0;
    while (!resp1_valid && lat < 20) begin step(); lat++; end
    pop(e, pok);
    tests++;
    if (!pok || lat != 1 || resp_res !== e.res || resp_zf !== e.zf || resp_err !== e.err) begin
      fails++;
      $display("FAIL bp_second: latency=%0d res=%h zf=%b want latency=1 res=%h zf=%b",
               lat, resp_res, resp_zf, e.res, e.zf);
    end
  endtask

  initial begin
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0; req0_ctrl = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0; req1_ctrl = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_contention();
    test_single_add();
    test_mul_div();
    test_slt();
    test_backpressure();
    tests++;
    if (sbq.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d entries left want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
